// File: rtl/bidir_port_ctrl.sv
// Tri-state bus controller: direction handover through a high-Z turnaround,
// valid/ready transmit, sampled receive and a sticky contention detector.
module bidir_port_ctrl #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned TURN_CYCLES = 2,
    parameter bit          CHECK_EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [WIDTH-1:0] data_line,
    input  logic             dir_req,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             rx_en,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             drive_en,
    output logic             busy_turn,
    output logic             contention,
    input  logic             clr_contention
);

    localparam int unsigned      CNT_W     = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {
        IN_MODE  = 2'd0,
        TURN_OUT = 2'd1,
        OUT_MODE = 2'd2,
        TURN_IN  = 2'd3
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] out_reg_q;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;
    logic             drive_en_q;
    logic             drive_en_prev_q;
    logic             busy_q;
    logic             cont_q;
    logic             armed;
    logic             mismatch;

    assign data_line = drive_en_q ? out_reg_q : {WIDTH{1'bz}};
    assign tx_ready  = (state_q == OUT_MODE) && dir_req;

    // The first driven cycle is skipped so the pad has settled before we compare.
    assign armed    = drive_en_q && drive_en_prev_q;
    assign mismatch = CHECK_EN && armed && (data_line !== out_reg_q);

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign drive_en   = drive_en_q;
    assign busy_turn  = busy_q;
    assign contention = cont_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IN_MODE;
            cnt_q           <= '0;
            out_reg_q       <= '0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            drive_en_q      <= 1'b0;
            drive_en_prev_q <= 1'b0;
            busy_q          <= 1'b0;
            cont_q          <= 1'b0;
        end else begin
            rx_valid_q      <= 1'b0;
            drive_en_prev_q <= drive_en_q;

            // Set takes priority over a simultaneous clear.
            if (mismatch) begin
                cont_q <= 1'b1;
            end else if (clr_contention) begin
                cont_q <= 1'b0;
            end

            unique case (state_q)
                IN_MODE: begin
                    if (rx_en) begin
                        rx_data_q  <= data_line;
                        rx_valid_q <= 1'b1;
                    end
                    if (dir_req) begin
                        state_q <= TURN_OUT;
                        cnt_q   <= TURN_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                TURN_OUT: begin
                    if (!dir_req) begin
                        state_q <= IN_MODE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q    <= OUT_MODE;
                        busy_q     <= 1'b0;
                        drive_en_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                OUT_MODE: begin
                    if (!dir_req) begin
                        state_q    <= TURN_IN;
                        cnt_q      <= TURN_LOAD;
                        busy_q     <= 1'b1;
                        drive_en_q <= 1'b0;
                    end else if (tx_valid) begin
                        out_reg_q <= tx_data;
                    end
                end
                TURN_IN: begin
                    if (cnt_q == '0) begin
                        state_q <= IN_MODE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IN_MODE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Bench for bidir_port_ctrl: phase-level model drives a receive scoreboard and
// a negedge monitor; a second instance with the detector disabled shares stimulus.
module tb_bidir_port_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned TC = 2;

    localparam int M_IN  = 0;
    localparam int M_TO  = 1;
    localparam int M_OUT = 2;
    localparam int M_TI  = 3;

    logic         clk;
    logic         rst_n;
    logic         clk_run;
    logic         dir_req;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         rx_en;
    logic         clr_contention;
    logic         ext_en;
    logic [W-1:0] ext_val;
    logic         inj;

    wire  [W-1:0] bus;
    wire  [W-1:0] bus2;
    logic         tx_ready,  tx_ready2;
    logic [W-1:0] rx_data,   rx_data2;
    logic         rx_valid,  rx_valid2;
    logic         drive_en,  drive_en2;
    logic         busy_turn, busy_turn2;
    logic         contention, contention2;

    assign bus  = ext_en ? ext_val : {W{1'bz}};
    assign bus2 = ext_en ? ext_val : {W{1'bz}};

    bidir_port_ctrl #(.WIDTH(W), .TURN_CYCLES(TC), .CHECK_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .data_line(bus), .dir_req(dir_req),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_en(rx_en), .rx_data(rx_data), .rx_valid(rx_valid),
        .drive_en(drive_en), .busy_turn(busy_turn), .contention(contention),
        .clr_contention(clr_contention)
    );

    bidir_port_ctrl #(.WIDTH(W), .TURN_CYCLES(TC), .CHECK_EN(1'b0)) u_nochk (
        .clk(clk), .rst_n(rst_n), .data_line(bus2), .dir_req(dir_req),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready2),
        .rx_en(rx_en), .rx_data(rx_data2), .rx_valid(rx_valid2),
        .drive_en(drive_en2), .busy_turn(busy_turn2), .contention(contention2),
        .clr_contention(clr_contention)
    );

    // Reference model: bus phase, dead cycles left, held word, sticky flag.
    int           m_mode;
    int           m_left;
    logic [W-1:0] m_out;
    bit           m_cont;
    bit           m_drove_prev;
    bit           m_rxv;
    logic [W-1:0] rxq[$];
    logic [W-1:0] exp_w;

    int n_checks;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode       = M_IN;
        m_left       = 0;
        m_out        = '0;
        m_cont       = 1'b0;
        m_drove_prev = 1'b0;
        m_rxv        = 1'b0;
        rxq.delete();
    endtask

    // Applies the rules for one clock edge using the inputs held across it.
    task automatic model_update();
        bit armed;
        armed = (m_mode == M_OUT) && m_drove_prev;
        m_rxv = 1'b0;
        if (armed && inj) m_cont = 1'b1;
        else if (clr_contention) m_cont = 1'b0;
        m_drove_prev = (m_mode == M_OUT);
        case (m_mode)
            M_IN: begin
                if (rx_en) begin
                    rxq.push_back(ext_val);
                    m_rxv = 1'b1;
                end
                if (dir_req) begin
                    m_mode = M_TO;
                    m_left = TC;
                end
            end
            M_TO: begin
                if (!dir_req) m_mode = M_IN;
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_OUT;
                end
            end
            M_OUT: begin
                if (!dir_req) begin
                    m_mode = M_TI;
                    m_left = TC;
                end else if (tx_valid) begin
                    m_out = tx_data;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_mode = M_IN;
            end
        endcase
    endtask

    task automatic drive(input bit d, input bit tv, input logic [W-1:0] td, input bit re,
                         input bit cl, input bit ij, input logic [W-1:0] ev);
        dir_req        = d;
        tx_valid       = tv;
        tx_data        = td;
        rx_en          = re;
        clr_contention = cl;
        inj            = ij;
        ext_val        = ev;
        ext_en         = (m_mode == M_IN) || ij;
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Stops the clock low, pulses reset, checks outputs without any edge.
    task automatic mid_reset();
        @(negedge clk);
        #1;
        clk_run = 1'b0;
        inj     = 1'b0;
        ext_en  = 1'b0;
        rst_n   = 1'b0;
        #2;
        chk("rst_drive_en",   32'(drive_en),   32'd0);
        chk("rst_busy_turn",  32'(busy_turn),  32'd0);
        chk("rst_contention", 32'(contention), 32'd0);
        chk("rst_rx_valid",   32'(rx_valid),   32'd0);
        chk("rst_rx_data",    32'(rx_data),    32'd0);
        chk("rst_tx_ready",   32'(tx_ready),   32'd0);
        chk("rst_drive_en2",  32'(drive_en2),  32'd0);
        model_reset();
        dir_req        = 1'b0;
        tx_valid       = 1'b0;
        rx_en          = 1'b0;
        clr_contention = 1'b0;
        ext_en         = 1'b1;
        #3;
        rst_n   = 1'b1;
        clk_run = 1'b1;
    endtask

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("drive_en",   32'(drive_en),   32'(m_mode == M_OUT));
            chk("busy_turn",  32'(busy_turn),  32'(m_mode == M_TO || m_mode == M_TI));
            chk("tx_ready",   32'(tx_ready),   32'(m_mode == M_OUT && dir_req));
            chk("contention", 32'(contention), 32'(m_cont));
            chk("rx_valid",   32'(rx_valid),   32'(m_rxv));
            chk("drive_en2",  32'(drive_en2),  32'(m_mode == M_OUT));
            chk("busy_turn2", 32'(busy_turn2), 32'(m_mode == M_TO || m_mode == M_TI));
            chk("tx_ready2",  32'(tx_ready2),  32'(m_mode == M_OUT && dir_req));
            chk("rx_valid2",  32'(rx_valid2),  32'(m_rxv));
            chk("contention2", 32'(contention2), 32'd0);
            if (m_mode == M_OUT && !inj) begin
                chk("bus",  32'(bus),  32'(m_out));
                chk("bus2", 32'(bus2), 32'(m_out));
            end
            if (rx_valid) begin
                if (rxq.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL rx_unexpected actual=%h expected=none at %0t", rx_data, $time);
                end else begin
                    exp_w = rxq.pop_front();
                    chk("rx_data",  32'(rx_data),  32'(exp_w));
                    chk("rx_data2", 32'(rx_data2), 32'(exp_w));
                end
            end
        end
    end

    initial begin
        bit           d;
        bit           ij;
        logic [W-1:0] ev;
        n_checks       = 0;
        n_err          = 0;
        clk_run        = 1'b1;
        rst_n          = 1'b0;
        dir_req        = 1'b0;
        tx_valid       = 1'b0;
        tx_data        = '0;
        rx_en          = 1'b0;
        clr_contention = 1'b0;
        inj            = 1'b0;
        ext_en         = 1'b1;
        ext_val        = '0;
        model_reset();
        #2;
        chk("init_drive_en",   32'(drive_en),   32'd0);
        chk("init_rx_data",    32'(rx_data),    32'd0);
        chk("init_contention", 32'(contention), 32'd0);
        #10;
        rst_n = 1'b1;

        // Receive sample, then idle with no further pulse.
        drive(0, 0, 8'h00, 1, 0, 0, 8'hA5);
        drive(0, 0, 8'h00, 0, 0, 0, 8'h11);
        drive(0, 0, 8'h00, 0, 0, 0, 8'h22);
        // Direction change with a simultaneous sample; rx ignored in turnaround.
        drive(1, 0, 8'h00, 1, 0, 0, 8'h96);
        drive(1, 0, 8'h00, 1, 0, 0, 8'h00);
        drive(1, 1, 8'h55, 1, 0, 0, 8'h00);
        drive(1, 1, 8'h3C, 0, 0, 0, 8'h00);
        drive(1, 0, 8'h00, 1, 0, 0, 8'h00);
        // Contention: set, clear, then set and clear together.
        drive(1, 0, 8'h00, 0, 0, 1, 8'hC3);
        drive(1, 0, 8'h00, 0, 0, 0, 8'h00);
        drive(1, 0, 8'h00, 0, 1, 0, 8'h00);
        drive(1, 0, 8'h00, 0, 1, 1, 8'hC3);
        drive(1, 0, 8'h00, 0, 0, 0, 8'h00);
        // Release with tx_valid held: never accepted.
        drive(0, 1, 8'h77, 0, 0, 0, 8'h00);
        drive(0, 1, 8'h77, 0, 0, 0, 8'h00);
        drive(0, 1, 8'h77, 0, 0, 0, 8'h00);
        drive(0, 0, 8'h00, 1, 0, 0, 8'h5A);
        drive(0, 0, 8'h00, 0, 0, 0, 8'h00);
        // Abort from the outbound turnaround.
        drive(1, 0, 8'h00, 0, 0, 0, 8'h00);
        drive(0, 0, 8'h00, 0, 0, 0, 8'h00);
        drive(0, 0, 8'h00, 0, 0, 0, 8'h00);
        // dir_req during the inbound turnaround waits for IN_MODE.
        for (int i = 0; i < 5; i++) drive(1, 0, 8'h00, 0, 0, 0, 8'h00);
        drive(0, 0, 8'h00, 0, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) drive(1, 0, 8'h00, 0, 0, 0, 8'h00);
        drive(1, 0, 8'h00, 0, 0, 1, 8'hC3);
        drive(1, 1, 8'h3C, 0, 0, 0, 8'h00);
        // Reset while driving with contention set, then drive the cleared word.
        mid_reset();
        for (int i = 0; i < 6; i++) drive(1, 0, 8'h00, 0, 0, 0, 8'h00);
        drive(0, 0, 8'h00, 0, 0, 0, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) mid_reset();
            d = dir_req;
            if ($urandom_range(0, 5) == 0) d = !d;
            ij = (m_mode == M_OUT) && (m_out != {W{1'b1}}) && ($urandom_range(0, 9) == 0);
            ev = ij ? ~m_out : W'($urandom);
            drive(d, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), ij, ev);
        end

        drive(0, 0, 8'h00, 0, 0, 0, 8'h00);
        @(negedge clk);
        #1;
        chk("rxq_drained", 32'(rxq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
